// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_ci.sv
// Combinational 4-bit ripple-carry adder slice with carry-in.
module add4_ci
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Ci,
    output logic [NIB_W-1:0] S,
    output logic             Co
);

    logic [NIB_W:0] c;

    // Ripple the carry bit by bit from Ci up to Co.
    always_comb begin
        S    = '0;
        c    = '0;
        c[0] = Ci;
        for (int i = 0; i < int'(NIB_W); i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Co = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer running one 4-bit adder slice over NIBBLES cycles, LS nibble first,
// for wide add/subtract with carry-out, signed overflow and zero flags.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [NIB_W*NIBBLES-1:0] op_a,
    input  logic [NIB_W*NIBBLES-1:0] op_b,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     carry_out,
    output logic                     overflow,
    output logic                     zero
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);

    state_t             state;
    state_t             state_next;

    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               sub_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;

    logic [31:0]        sh;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_co;
    logic               last;
    logic               ovf_c;
    logic [W-1:0]       result_step;

    // Select the active nibble; B is inverted for subtraction before the adder.
    always_comb begin
        sh          = 32'(idx) * 32'(NIB_W);
        a_nib       = NIB_W'(a_reg >> sh);
        b_nib       = NIB_W'(b_reg >> sh) ^ {NIB_W{sub_reg}};
        last        = (idx == IDX_W'(NIBBLES - 1));
        ovf_c       = (a_nib[NIB_W-1] == b_nib[NIB_W-1]) &&
                      (slice_sum[NIB_W-1] != a_nib[NIB_W-1]);
        result_step = (result & ~(W'({NIB_W{1'b1}}) << sh)) | (W'(slice_sum) << sh);
    end

    add4_ci u_add4 (
        .A  (a_nib),
        .B  (b_nib),
        .Ci (carry_reg),
        .S  (slice_sum),
        .Co (slice_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last nibble, DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, nibble stepping, flag capture and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_next == ST_RUN);
            done <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        idx       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result    <= result_step;
                    carry_reg <= slice_co;
                    if (last) begin
                        carry_out <= slice_co;
                        overflow  <= ovf_c;
                        zero      <= (result_step == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: cycle model plus directed vectors for NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder_ctrl;

    localparam int N4 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub;
    logic [15:0] op_a, op_b;
    logic        busy, done, carry_out, overflow, zero;
    logic [15:0] result;

    logic        start1, sub1;
    logic [3:0]  op_a1, op_b1;
    logic        busy1, done1, co1, ov1, z1;
    logic [3:0]  result1;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .op_a(op_a1), .op_b(op_b1),
        .busy(busy1), .done(done1), .result(result1), .carry_out(co1),
        .overflow(ov1), .zero(z1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {zero, overflow, carry, result}.
    function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] sum;
        logic [15:0] res;
        logic        co, ov;
        int          r;
        if (s) begin
            res = a - b;
            co  = (a >= b);
            r   = int'($signed(a)) - int'($signed(b));
        end else begin
            sum = 17'(a) + 17'(b);
            res = sum[15:0];
            co  = sum[16];
            r   = int'($signed(a)) + int'($signed(b));
        end
        ov = (r > 32767) || (r < -32768);
        return {(res == 16'h0), ov, co, res};
    endfunction

    // Model: m_cnt = 0 idle, 1..N4 running, N4+1 done cycle.
    int          m_cnt = 0;
    logic [15:0] e_res = '0, h_res = '0;
    logic        e_co = 0, e_ov = 0, e_z = 0, h_co = 0, h_ov = 0, h_z = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            {h_z, h_ov, h_co, h_res} = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                {e_z, e_ov, e_co, e_res} = ref_op(op_a, op_b, sub);
                {h_z, h_ov, h_co, h_res} = '0;
                m_cnt = 1;
            end
        end else if (m_cnt == N4 + 1) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == N4 + 1) {h_z, h_ov, h_co, h_res} = {e_z, e_ov, e_co, e_res};
        end
    end

    // Cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] mk;
            logic [15:0] x_res;
            logic        x_co, x_ov, x_z;
            if (m_cnt >= 1 && m_cnt <= N4) begin
                mk    = (32'd1 << (4 * (m_cnt - 1))) - 32'd1;
                x_res = e_res & mk[15:0];
                {x_z, x_ov, x_co} = '0;
            end else begin
                {x_z, x_ov, x_co, x_res} = {h_z, h_ov, h_co, h_res};
            end
            check("cyc_busy",   32'(busy),      32'(m_cnt >= 1 && m_cnt <= N4));
            check("cyc_done",   32'(done),      32'(m_cnt == N4 + 1));
            check("cyc_result", 32'(result),    32'(x_res));
            check("cyc_carry",  32'(carry_out), 32'(x_co));
            check("cyc_ovf",    32'(overflow),  32'(x_ov));
            check("cyc_zero",   32'(zero),      32'(x_z));
        end
    end

    // Issue one operation and check latency, busy length and literal results.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] x_res, input logic x_co, input logic x_ov,
                          input logic x_z, input string name, input bit disturb);
        int lat, nbusy;
        @(posedge clk); #2;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (disturb) begin
            op_a = ~a; op_b = ~b; sub = ~s;
        end
        lat = 0; nbusy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (disturb && k == 2) start = 1'b1;
            if (disturb && k == 3) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(N4 + 1));
        check({name, "_busycnt"}, 32'(nbusy), 32'(N4));
        check({name, "_result"}, 32'(result), 32'(x_res));
        check({name, "_carry"}, 32'(carry_out), 32'(x_co));
        check({name, "_ovf"}, 32'(overflow), 32'(x_ov));
        check({name, "_zero"}, 32'(zero), 32'(x_z));
    endtask

    initial begin
        int lat, ndone;
        rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        start1 = 1'b0; sub1 = 1'b0; op_a1 = '0; op_b1 = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst_outputs", 32'({busy, done, carry_out, overflow, zero, result}), 32'd0);
        check("rst_outputs1", 32'({busy1, done1, co1, ov1, z1, result1}), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "add_00ff", 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_7fff", 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_ffff", 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_5_7", 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_8000", 1'b0);
        run_op(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, "ignore_run", 1'b1);
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, "after_done", 1'b0);

        // Reset two cycles into RUN aborts without a done pulse.
        @(posedge clk); #2;
        op_a = 16'h1111; op_b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_partial_nonzero", 32'(result != 16'h0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_outputs", 32'({busy, done, carry_out, overflow, zero, result}), 32'd0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // Start in the same cycle as reset is not accepted.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op_a = 16'h0042; op_b = 16'h0001;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_start_busy", 32'(busy), 32'd0);
        end

        // Single-nibble build: 9+9.
        @(posedge clk); #2;
        op_a1 = 4'h9; op_b1 = 4'h9; sub1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check("n1_busy", 32'(busy1), 32'd1);
            if (done1) begin
                lat = k;
                break;
            end
        end
        check("n1_latency", 32'(lat), 32'd2);
        check("n1_result", 32'(result1), 32'h2);
        check("n1_carry", 32'(co1), 32'd1);
        check("n1_ovf", 32'(ov1), 32'd1);
        check("n1_zero", 32'(z1), 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
